// File: rtl/alu_seq_pkg.sv
// Shared types for the ALU operand sequencer: FSM state encoding and the
// phase tags shown on the display.
package alu_seq_pkg;

    typedef enum logic [2:0] {
        LOAD_A,
        LOAD_B,
        START,
        WAIT,
        SHOW
    } state_e;

    localparam logic [3:0] PH_A = 4'hA;
    localparam logic [3:0] PH_B = 4'hB;
    localparam logic [3:0] PH_R = 4'hC;

endpackage

// File: rtl/alu_seq_ctrl_if.sv
// Bundle between the operand sequencer and its environment (switches,
// enter strobe, external ALU and the display).
interface alu_seq_ctrl_if;

    logic        pulse;
    logic        clear;
    logic [7:0]  inputdata;
    logic [1:0]  opcode;
    logic        alu_done;
    logic [31:0] alu_result;
    logic [4:0]  alu_flags;
    logic [31:0] dataA;
    logic [31:0] dataB;
    logic [1:0]  alu_op;
    logic        alu_start;
    logic [31:0] dataR;
    logic [4:0]  flags;
    logic [3:0]  phase;
    logic [1:0]  byte_idx;
    logic        busy;
    logic        error;

    modport master (
        output pulse, clear, inputdata, opcode, alu_done, alu_result, alu_flags,
        input  dataA, dataB, alu_op, alu_start, dataR, flags, phase, byte_idx, busy, error
    );

    modport slave (
        input  pulse, clear, inputdata, opcode, alu_done, alu_result, alu_flags,
        output dataA, dataB, alu_op, alu_start, dataR, flags, phase, byte_idx, busy, error
    );

endinterface

// File: rtl/seq_timeout.sv
// Wait-cycle counter: counts enabled cycles and flags the TIMEOUT-th one.
module seq_timeout #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

    logic [W-1:0] count_q;

    // Count holds TIMEOUT-1 during the last waited cycle, so expiry lands on
    // the TIMEOUT-th clock edge after the counter was cleared.
    assign expired = enable && (count_q == LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (enable && !expired) begin
            count_q <= count_q + W'(1);
        end
    end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Operand sequencer: loads two 32-bit operands a byte at a time, launches the
// ALU, waits for its result with a timeout, then lets the user page the result.
module alu_seq_ctrl
    import alu_seq_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    alu_seq_ctrl_if.slave     bus
);

    state_e      state_q;
    logic [31:0] data_a_q, data_b_q, data_r_q;
    logic [4:0]  flags_q;
    logic [1:0]  alu_op_q, byte_idx_q;
    logic [3:0]  phase_q;
    logic        alu_start_q, busy_q, error_q;
    logic        tmo_expired;

    seq_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clear   (bus.clear || (state_q == START)),
        .enable  (state_q == WAIT),
        .expired (tmo_expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= LOAD_A;
            data_a_q    <= '0;
            data_b_q    <= '0;
            data_r_q    <= '0;
            flags_q     <= '0;
            alu_op_q    <= '0;
            byte_idx_q  <= '0;
            phase_q     <= PH_A;
            alu_start_q <= 1'b0;
            busy_q      <= 1'b0;
            error_q     <= 1'b0;
        end else if (bus.clear) begin
            state_q     <= LOAD_A;
            byte_idx_q  <= '0;
            phase_q     <= PH_A;
            alu_start_q <= 1'b0;
            busy_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            unique case (state_q)
                LOAD_A: if (bus.pulse) begin
                    data_a_q[{byte_idx_q, 3'b000} +: 8] <= bus.inputdata;
                    byte_idx_q <= byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        state_q <= LOAD_B;
                        phase_q <= PH_B;
                    end
                end
                LOAD_B: if (bus.pulse) begin
                    data_b_q[{byte_idx_q, 3'b000} +: 8] <= bus.inputdata;
                    byte_idx_q <= byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        // Launch and opcode latch coincide so alu_op is stable
                        // for the whole alu_start cycle.
                        state_q     <= START;
                        phase_q     <= PH_R;
                        alu_start_q <= 1'b1;
                        alu_op_q    <= bus.opcode;
                        error_q     <= 1'b0;
                    end
                end
                START: begin
                    state_q     <= WAIT;
                    alu_start_q <= 1'b0;
                    busy_q      <= 1'b1;
                end
                WAIT: begin
                    if (bus.alu_done) begin
                        data_r_q   <= bus.alu_result;
                        flags_q    <= bus.alu_flags;
                        byte_idx_q <= '0;
                        busy_q     <= 1'b0;
                        state_q    <= SHOW;
                    end else if (tmo_expired) begin
                        data_r_q   <= '0;
                        flags_q    <= '0;
                        error_q    <= 1'b1;
                        byte_idx_q <= '0;
                        busy_q     <= 1'b0;
                        state_q    <= SHOW;
                    end
                end
                SHOW: if (bus.pulse) begin
                    byte_idx_q <= byte_idx_q + 2'd1;
                end
                default: begin
                    state_q <= LOAD_A;
                    phase_q <= PH_A;
                end
            endcase
        end
    end

    assign bus.dataA     = data_a_q;
    assign bus.dataB     = data_b_q;
    assign bus.dataR     = data_r_q;
    assign bus.flags     = flags_q;
    assign bus.alu_op    = alu_op_q;
    assign bus.alu_start = alu_start_q;
    assign bus.phase     = phase_q;
    assign bus.byte_idx  = byte_idx_q;
    assign bus.busy      = busy_q;
    assign bus.error     = error_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl with a 16-cycle timeout.
module tb_alu_seq_ctrl;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    alu_seq_ctrl_if bus ();

    alu_seq_ctrl #(
        .TIMEOUT (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic press(input logic [7:0] b);
        bus.inputdata = b;
        bus.pulse     = 1'b1;
        tick();
        bus.pulse     = 1'b0;
    endtask

    task automatic do_clear();
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
    endtask

    initial begin
        logic [1:0] show_seq [5];
        show_seq = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

        reset          = 1'b1;
        bus.pulse      = 1'b0;
        bus.clear      = 1'b0;
        bus.inputdata  = 8'h00;
        bus.opcode     = 2'd0;
        bus.alu_done   = 1'b0;
        bus.alu_result = 32'h0;
        bus.alu_flags  = 5'h0;
        tick();
        tick();
        chk("rst_phase", 32'(bus.phase), 32'hA);
        chk("rst_idx", 32'(bus.byte_idx), 32'd0);
        chk("rst_dataA", bus.dataA, 32'h0);
        chk("rst_dataB", bus.dataB, 32'h0);
        chk("rst_dataR", bus.dataR, 32'h0);
        chk("rst_flags", 32'(bus.flags), 32'h0);
        chk("rst_op", 32'(bus.alu_op), 32'd0);
        chk("rst_start", 32'(bus.alu_start), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_error", 32'(bus.error), 32'd0);
        reset = 1'b0;
        tick();

        // Normal operation
        bus.opcode = 2'd2;
        press(8'h11); press(8'h22); press(8'h33);
        chk("a3_idx", 32'(bus.byte_idx), 32'd3);
        chk("a3_phase", 32'(bus.phase), 32'hA);
        press(8'h44);
        chk("a4_phase", 32'(bus.phase), 32'hB);
        chk("a4_idx", 32'(bus.byte_idx), 32'd0);
        chk("dataA", bus.dataA, 32'h44332211);
        press(8'h55); press(8'h66); press(8'h77);
        chk("b3_start", 32'(bus.alu_start), 32'd0);
        press(8'h88);
        chk("start_hi", 32'(bus.alu_start), 32'd1);
        chk("start_phase", 32'(bus.phase), 32'hC);
        chk("dataB", bus.dataB, 32'h88776655);
        chk("alu_op", 32'(bus.alu_op), 32'd2);
        chk("start_busy", 32'(bus.busy), 32'd0);
        bus.opcode = 2'd0;
        tick();
        chk("start_lo", 32'(bus.alu_start), 32'd0);
        chk("wait_busy", 32'(bus.busy), 32'd1);
        chk("op_held", 32'(bus.alu_op), 32'd2);
        bus.pulse = 1'b1;
        tick();
        tick();
        bus.pulse = 1'b0;
        chk("wait_pulse_idx", 32'(bus.byte_idx), 32'd0);
        chk("wait_pulse_busy", 32'(bus.busy), 32'd1);
        tick();
        bus.alu_result = 32'hDEADBEEF;
        bus.alu_flags  = 5'b00010;
        bus.alu_done   = 1'b1;
        tick();
        bus.alu_done   = 1'b0;
        chk("dataR", bus.dataR, 32'hDEADBEEF);
        chk("flags", 32'(bus.flags), 32'h2);
        chk("show_phase", 32'(bus.phase), 32'hC);
        chk("show_idx", 32'(bus.byte_idx), 32'd0);
        chk("show_error", 32'(bus.error), 32'd0);
        chk("show_busy", 32'(bus.busy), 32'd0);

        for (int i = 0; i < 5; i++) begin
            press(8'h00);
            chk($sformatf("show_idx%0d", i), 32'(bus.byte_idx), 32'(show_seq[i]));
        end
        bus.alu_result = 32'h12345678;
        bus.alu_done   = 1'b1;
        tick();
        bus.alu_done   = 1'b0;
        chk("done_in_show", bus.dataR, 32'hDEADBEEF);

        bus.clear = 1'b1;
        bus.pulse = 1'b1;
        tick();
        bus.clear = 1'b0;
        bus.pulse = 1'b0;
        chk("clr_phase", 32'(bus.phase), 32'hA);
        chk("clr_idx", 32'(bus.byte_idx), 32'd0);
        chk("clr_dataR", bus.dataR, 32'hDEADBEEF);
        chk("clr_dataA", bus.dataA, 32'h44332211);

        // Timeout: SHOW on the 16th edge after entering WAIT
        bus.opcode = 2'd1;
        press(8'hA1); press(8'hA2); press(8'hA3); press(8'hA4);
        chk("dataA2", bus.dataA, 32'hA4A3A2A1);
        press(8'hB1); press(8'hB2); press(8'hB3); press(8'hB4);
        chk("start2", 32'(bus.alu_start), 32'd1);
        tick();
        repeat (15) tick();
        chk("tmo_busy15", 32'(bus.busy), 32'd1);
        chk("tmo_err15", 32'(bus.error), 32'd0);
        tick();
        chk("tmo_busy16", 32'(bus.busy), 32'd0);
        chk("tmo_error", 32'(bus.error), 32'd1);
        chk("tmo_dataR", bus.dataR, 32'h0);
        chk("tmo_flags", 32'(bus.flags), 32'h0);
        chk("tmo_phase", 32'(bus.phase), 32'hC);
        chk("tmo_idx", 32'(bus.byte_idx), 32'd0);
        do_clear();
        chk("clr_error", 32'(bus.error), 32'd0);
        chk("clr_phase2", 32'(bus.phase), 32'hA);

        // alu_done on the expiry cycle wins
        press(8'hA1); press(8'hA2); press(8'hA3); press(8'hA4);
        press(8'hB1); press(8'hB2); press(8'hB3); press(8'hB4);
        tick();
        repeat (15) tick();
        bus.alu_result = 32'hCAFEF00D;
        bus.alu_flags  = 5'b10001;
        bus.alu_done   = 1'b1;
        tick();
        bus.alu_done   = 1'b0;
        chk("tie_dataR", bus.dataR, 32'hCAFEF00D);
        chk("tie_flags", 32'(bus.flags), 32'h11);
        chk("tie_error", 32'(bus.error), 32'd0);
        chk("tie_busy", 32'(bus.busy), 32'd0);
        do_clear();

        // Clear beats pulse mid-load of dataA
        press(8'h5A); press(8'h5B); press(8'h5C);
        chk("pre_clr_idx", 32'(bus.byte_idx), 32'd3);
        bus.inputdata = 8'hFF;
        bus.clear     = 1'b1;
        bus.pulse     = 1'b1;
        tick();
        bus.clear     = 1'b0;
        bus.pulse     = 1'b0;
        chk("clrp_idx", 32'(bus.byte_idx), 32'd0);
        chk("clrp_phase", 32'(bus.phase), 32'hA);
        chk("clrp_dataA", bus.dataA, 32'hA45C5B5A);

        // Reset mid-WAIT abandons the operation
        for (int i = 1; i <= 8; i++) press(8'(i));
        tick();
        tick();
        chk("pre_rst_busy", 32'(bus.busy), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("arst_phase", 32'(bus.phase), 32'hA);
        chk("arst_busy", 32'(bus.busy), 32'd0);
        chk("arst_dataA", bus.dataA, 32'h0);
        #1 reset = 1'b0;
        bus.alu_result = 32'h11111111;
        bus.alu_done   = 1'b1;
        tick();
        bus.alu_done   = 1'b0;
        chk("post_rst_dataR", bus.dataR, 32'h0);
        chk("post_rst_start", 32'(bus.alu_start), 32'd0);
        chk("post_rst_phase", 32'(bus.phase), 32'hA);
        chk("post_rst_busy", 32'(bus.busy), 32'd0);
        tick();
        chk("post_rst_start2", 32'(bus.alu_start), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
